// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg
// Shared definitions for the FIFO-fed UART transmitter.
//   tx_state_t  : transmitter frame state
//   TX_IDLE_LVL : level of the serial line between frames (mark)
package fifo_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic TX_IDLE_LVL = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// uart_bit_timer
// Baud counter for the UART transmitter. Counts 0..CLKS_PER_BIT-1 while
// run is high and flags the last cycle of each bit period.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   run      : count while high; counter is held at zero while low
//   restart  : synchronously clear the counter (start of a new frame)
//   bit_done : high on the last cycle of each bit period
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic bit_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] baud_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else if (restart || !run) begin
            baud_cnt <= '0;
        end else if (baud_cnt == LAST_CNT) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // Must not depend on restart: restart is derived from bit_done in the
    // top-level load decision, so using it here would close a comb loop.
    assign bit_done = run && (baud_cnt == LAST_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Drains a first-word-fall-through FIFO and serialises each word as a
// start bit, DATA_WIDTH data bits (LSB first) and one stop bit on tx.
// Frames chain without an idle gap while the FIFO stays non-empty.
// Ports:
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   enable       : permits new frames, sampled at frame-start decisions
//   fifo_empty   : FIFO empty flag
//   fifo_rd_data : FIFO head word, valid while fifo_empty is low
//   fifo_rd_en   : pop strobe, one cycle per consumed word
//   tx           : registered serial output, idles high
//   busy         : registered, high while a frame is in progress
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic [IDX_W-1:0]      bit_idx;
    logic                  bit_done;
    logic                  frame_end;
    logic                  load;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (state != IDLE),
        .restart  (load),
        .bit_done (bit_done)
    );

    assign frame_end = (state == STOP) && bit_done;

    // rst_n gates the pop so a word is never consumed while the block is
    // held in reset (state reads IDLE then, which would otherwise qualify).
    assign load       = rst_n && enable && !fifo_empty && ((state == IDLE) || frame_end);
    assign fifo_rd_en = load;

    assign shift_nxt = shift_reg >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx        <= TX_IDLE_LVL;
            busy      <= 1'b0;
            shift_reg <= '0;
            bit_idx   <= '0;
        end else if (load) begin
            state     <= START;
            tx        <= ~TX_IDLE_LVL;
            busy      <= 1'b1;
            shift_reg <= fifo_rd_data;
            bit_idx   <= '0;
        end else if (bit_done) begin
            unique case (state)
                START: begin
                    state <= DATA;
                    tx    <= shift_reg[0];
                end
                DATA: begin
                    if (bit_idx == LAST_IDX) begin
                        state <= STOP;
                        tx    <= TX_IDLE_LVL;
                    end else begin
                        bit_idx   <= bit_idx + 1'b1;
                        shift_reg <= shift_nxt;
                        tx        <= shift_nxt[0];
                    end
                end
                STOP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int FRAME = (DW + 2) * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .tx           (tx),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // bench FIFO contents (head at index 0)
    logic [DW-1:0] fq[$];

    // reference model: the frame currently expected on the line
    int            fr_start = 0;
    logic [DW-1:0] fr_byte  = '0;
    bit            fr_valid = 1'b0;

    logic s_tx, s_busy, s_rd;
    logic e_tx, e_busy, e_rd;
    logic [DW-1:0] last_pop = '0;

    task automatic sync_fifo();
        fifo_empty   = (fq.size() == 0);
        fifo_rd_data = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] b);
        fq.push_back(b);
        sync_fifo();
    endtask

    // One clock cycle: predict outputs from the frame rules, sample the DUT
    // mid-cycle, then let the bench FIFO react to the pop strobe.
    task automatic step();
        int slot;
        @(negedge clk);
        if (!rst_n) fr_valid = 1'b0;
        e_tx   = 1'b1;
        e_busy = 1'b0;
        if (fr_valid && cyc >= fr_start && cyc < fr_start + FRAME) begin
            slot   = (cyc - fr_start) / CPB;
            e_busy = 1'b1;
            if (slot == 0)       e_tx = 1'b0;
            else if (slot <= DW) e_tx = fr_byte[slot-1];
            else                 e_tx = 1'b1;
        end
        e_rd = rst_n && enable && (fq.size() != 0) &&
               (!e_busy || cyc == fr_start + FRAME - 1);
        if (e_rd) begin
            fr_start = cyc + 1;
            fr_byte  = fq[0];
            fr_valid = 1'b1;
        end
        s_tx   = tx;
        s_busy = busy;
        s_rd   = fifo_rd_en;
        @(posedge clk);
        #1;
        if (s_rd && fq.size() != 0) begin
            last_pop = fq[0];
            void'(fq.pop_front());
        end
        sync_fifo();
        cyc++;
    endtask

    task automatic test_reset();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({s_tx, s_busy, s_rd} !== 3'b100) begin
                n_bad++;
                $display("FAIL reset_state cyc=%0d got tx/busy/rd=%b%b%b want 100", cyc, s_tx, s_busy, s_rd);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_empty();
        int pops = 0;
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (s_rd) pops++;
            n_cmp++;
            if ({s_tx, s_busy, s_rd} !== {e_tx, e_busy, e_rd}) begin
                n_bad++;
                $display("FAIL idle_empty cyc=%0d got tx/busy/rd=%b%b%b want %b%b%b", cyc, s_tx, s_busy, s_rd, e_tx, e_busy, e_rd);
            end
        end
        n_cmp++;
        if (pops !== 0) begin
            n_bad++;
            $display("FAIL idle_pops got %0d want 0", pops);
        end
    endtask

    task automatic test_single();
        int pops = 0;
        int busy_cnt = 0;
        enable = 1'b0;
        push(8'hA5);
        step();
        enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (s_rd) pops++;
            if (s_busy) busy_cnt++;
            n_cmp++;
            if ({s_tx, s_busy, s_rd} !== {e_tx, e_busy, e_rd}) begin
                n_bad++;
                $display("FAIL single_frame cyc=%0d got tx/busy/rd=%b%b%b want %b%b%b", cyc, s_tx, s_busy, s_rd, e_tx, e_busy, e_rd);
            end
        end
        n_cmp++;
        if (pops !== 1) begin
            n_bad++;
            $display("FAIL single_pops got %0d want 1", pops);
        end
        n_cmp++;
        if (busy_cnt !== FRAME) begin
            n_bad++;
            $display("FAIL single_busy_len got %0d want %0d", busy_cnt, FRAME);
        end
    endtask

    task automatic test_back_to_back();
        int pop_cyc[$];
        int busy_cnt = 0;
        int first_b = -1;
        int last_b = -1;
        enable = 1'b1;
        push(8'h00);
        push(8'hFF);
        for (int i = 0; i < 95; i++) begin
            step();
            if (s_rd) pop_cyc.push_back(cyc - 1);
            if (s_busy) begin
                busy_cnt++;
                if (first_b < 0) first_b = cyc - 1;
                last_b = cyc - 1;
            end
            n_cmp++;
            if ({s_tx, s_busy, s_rd} !== {e_tx, e_busy, e_rd}) begin
                n_bad++;
                $display("FAIL b2b_frame cyc=%0d got tx/busy/rd=%b%b%b want %b%b%b", cyc, s_tx, s_busy, s_rd, e_tx, e_busy, e_rd);
            end
        end
        n_cmp++;
        if (pop_cyc.size() !== 2) begin
            n_bad++;
            $display("FAIL b2b_pops got %0d want 2", pop_cyc.size());
        end else begin
            n_cmp++;
            if (pop_cyc[1] - pop_cyc[0] !== FRAME) begin
                n_bad++;
                $display("FAIL b2b_spacing got %0d want %0d", pop_cyc[1] - pop_cyc[0], FRAME);
            end
        end
        n_cmp++;
        if (busy_cnt !== 2 * FRAME || last_b - first_b + 1 !== 2 * FRAME) begin
            n_bad++;
            $display("FAIL b2b_gapless got busy=%0d span=%0d want %0d", busy_cnt, last_b - first_b + 1, 2 * FRAME);
        end
        n_cmp++;
        if ({fifo_empty, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL b2b_end got empty/busy=%b%b want 10", fifo_empty, busy);
        end
    endtask

    task automatic test_enable_drop();
        bit got = 1'b0;
        int pops = 0;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) push(DW'($urandom_range(0, 255)));
        for (int i = 0; i < 5 && !got; i++) begin
            step();
            if (s_rd) got = 1'b1;
            n_cmp++;
            if ({s_tx, s_busy, s_rd} !== {e_tx, e_busy, e_rd}) begin
                n_bad++;
                $display("FAIL endrop_start cyc=%0d got tx/busy/rd=%b%b%b want %b%b%b", cyc, s_tx, s_busy, s_rd, e_tx, e_busy, e_rd);
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL endrop_first_pop got none want 1");
        end
        for (int i = 0; i < 20 && cyc < fr_start + 10 + $urandom_range(0, 8); i++) step();
        enable = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (s_rd) pops++;
            n_cmp++;
            if ({s_tx, s_busy, s_rd} !== {e_tx, e_busy, e_rd}) begin
                n_bad++;
                $display("FAIL endrop_hold cyc=%0d got tx/busy/rd=%b%b%b want %b%b%b", cyc, s_tx, s_busy, s_rd, e_tx, e_busy, e_rd);
            end
        end
        n_cmp++;
        if (pops !== 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL endrop_no_pop got pops=%0d busy=%b want 0 0", pops, busy);
        end
        enable = 1'b1;
        step();
        n_cmp++;
        if (s_rd !== 1'b1) begin
            n_bad++;
            $display("FAIL endrop_resume got rd=%b want 1", s_rd);
        end
        for (int i = 0; i < 2 * FRAME + 5; i++) begin
            step();
            n_cmp++;
            if ({s_tx, s_busy, s_rd} !== {e_tx, e_busy, e_rd}) begin
                n_bad++;
                $display("FAIL endrop_drain cyc=%0d got tx/busy/rd=%b%b%b want %b%b%b", cyc, s_tx, s_busy, s_rd, e_tx, e_busy, e_rd);
            end
        end
        n_cmp++;
        if (fq.size() !== 0) begin
            n_bad++;
            $display("FAIL endrop_drained got %0d words want 0", fq.size());
        end
    endtask

    task automatic test_reset_mid();
        bit got = 1'b0;
        enable = 1'b0;
        push(8'h3C);
        push(8'h81);
        enable = 1'b1;
        for (int i = 0; i < 5 && !got; i++) begin
            step();
            if (s_rd) got = 1'b1;
        end
        n_cmp++;
        if (!got || last_pop !== 8'h3C) begin
            n_bad++;
            $display("FAIL rstmid_pop got popped=%b byte=%h want 1 3c", got, last_pop);
        end
        // data bit 3 spans frame offsets 16..19
        for (int i = 0; i < 30 && cyc < fr_start + 17; i++) begin
            step();
            n_cmp++;
            if ({s_tx, s_busy, s_rd} !== {e_tx, e_busy, e_rd}) begin
                n_bad++;
                $display("FAIL rstmid_frame cyc=%0d got tx/busy/rd=%b%b%b want %b%b%b", cyc, s_tx, s_busy, s_rd, e_tx, e_busy, e_rd);
            end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tx, busy, fifo_rd_en} !== 3'b100) begin
            n_bad++;
            $display("FAIL rstmid_async got tx/busy/rd=%b%b%b want 100", tx, busy, fifo_rd_en);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < FRAME + 5; i++) begin
            step();
            n_cmp++;
            if ({s_tx, s_busy, s_rd} !== {e_tx, e_busy, e_rd}) begin
                n_bad++;
                $display("FAIL rstmid_after cyc=%0d got tx/busy/rd=%b%b%b want %b%b%b", cyc, s_tx, s_busy, s_rd, e_tx, e_busy, e_rd);
            end
        end
        n_cmp++;
        if (last_pop !== 8'h81 || fq.size() !== 0) begin
            n_bad++;
            $display("FAIL rstmid_next got byte=%h left=%0d want 81 0", last_pop, fq.size());
        end
    endtask

    task automatic test_chain();
        bit got = 1'b0;
        int f0;
        int chain_cyc = -1;
        logic [DW-1:0] b1;
        enable = 1'b1;
        push(DW'($urandom_range(0, 255)));
        for (int i = 0; i < 5 && !got; i++) begin
            step();
            if (s_rd) got = 1'b1;
        end
        f0 = fr_start;
        // STOP occupies offsets 36..39; second STOP cycle is offset 37
        for (int i = 0; i < 50 && cyc < f0 + FRAME - 3; i++) begin
            step();
            n_cmp++;
            if ({s_tx, s_busy, s_rd} !== {e_tx, e_busy, e_rd}) begin
                n_bad++;
                $display("FAIL chain_frame1 cyc=%0d got tx/busy/rd=%b%b%b want %b%b%b", cyc, s_tx, s_busy, s_rd, e_tx, e_busy, e_rd);
            end
        end
        b1 = DW'($urandom_range(0, 255));
        push(b1);
        for (int i = 0; i < FRAME + 8; i++) begin
            step();
            if (s_rd && chain_cyc < 0) chain_cyc = cyc - 1;
            n_cmp++;
            if ({s_tx, s_busy, s_rd} !== {e_tx, e_busy, e_rd}) begin
                n_bad++;
                $display("FAIL chain_frame2 cyc=%0d got tx/busy/rd=%b%b%b want %b%b%b", cyc, s_tx, s_busy, s_rd, e_tx, e_busy, e_rd);
            end
        end
        n_cmp++;
        if (chain_cyc !== f0 + FRAME - 1 || last_pop !== b1) begin
            n_bad++;
            $display("FAIL chain_load got pop_cyc=%0d byte=%h want %0d %h", chain_cyc, last_pop, f0 + FRAME - 1, b1);
        end
    endtask

    task automatic test_reset_random();
        for (int it = 0; it < 4; it++) begin
            bit got = 1'b0;
            int k;
            enable = 1'b1;
            push(DW'($urandom_range(0, 255)));
            for (int i = 0; i < 5 && !got; i++) begin
                step();
                if (s_rd) got = 1'b1;
            end
            k = $urandom_range(0, FRAME - 2);
            for (int i = 0; i < k; i++) begin
                step();
                n_cmp++;
                if ({s_tx, s_busy, s_rd} !== {e_tx, e_busy, e_rd}) begin
                    n_bad++;
                    $display("FAIL rstrnd_frame cyc=%0d got tx/busy/rd=%b%b%b want %b%b%b", cyc, s_tx, s_busy, s_rd, e_tx, e_busy, e_rd);
                end
            end
            rst_n = 1'b0;
            #1;
            n_cmp++;
            if ({tx, busy} !== 2'b10) begin
                n_bad++;
                $display("FAIL rstrnd_async off=%0d got tx/busy=%b%b want 10", k, tx, busy);
            end
            step();
            rst_n = 1'b1;
            step();
        end
    endtask

    task automatic test_random();
        enable = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0 && fq.size() < 4) push(DW'($urandom));
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            step();
            n_cmp++;
            if ({s_tx, s_busy, s_rd} !== {e_tx, e_busy, e_rd}) begin
                n_bad++;
                $display("FAIL random cyc=%0d got tx/busy/rd=%b%b%b want %b%b%b", cyc, s_tx, s_busy, s_rd, e_tx, e_busy, e_rd);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 5 * FRAME; i++) begin
            step();
            n_cmp++;
            if ({s_tx, s_busy, s_rd} !== {e_tx, e_busy, e_rd}) begin
                n_bad++;
                $display("FAIL random_drain cyc=%0d got tx/busy/rd=%b%b%b want %b%b%b", cyc, s_tx, s_busy, s_rd, e_tx, e_busy, e_rd);
            end
        end
    endtask

    initial begin
        sync_fifo();
        test_reset();
        test_idle_empty();
        test_single();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_chain();
        test_reset_random();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
